// File: rtl/ascon_pack.sv
// Shared types and constants for the ascon job scheduler.
package ascon_pack;

  localparam int NREQ_MAX = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } sched_state_t;

  // Index width for a requester count, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping upward.
module rr_arbiter
  import ascon_pack::*;
#(
  parameter int NREQ = 2,
  localparam int IW  = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  logic [2*NREQ-1:0] rot;
  int                sum;

  // NOTE: every output gets a default before the search loop, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    sum   = 0;
    // Doubling the vector turns the wrap-around scan into a plain lowest-bit search.
    rot   = {req, req} >> ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!valid && rot[i]) begin
        valid = 1'b1;
        sum   = int'(ptr) + i;
        if (sum >= NREQ) sum = sum - NREQ;
        idx   = IW'(sum);
      end
    end
    if (valid) gnt = {{(NREQ-1){1'b0}}, 1'b1} << idx;
  end

endmodule

// File: rtl/ascon_sched.sv
// Round-robin scheduler sharing one ascon core among NREQ requesters.
// Optional ASCON_SCHED_STATS_EN adds per-requester completed-job counters on jobs_o.
module ascon_sched
  import ascon_pack::*;
#(
  parameter int NREQ      = 2,
  parameter int BLK_AD_AW = 10,
  parameter int BLK_PT_AW = 10
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NREQ-1:0]                req_i,
  input  logic [NREQ-1:0][127:0]         key_i,
  input  logic [NREQ-1:0][127:0]         nonce_i,
  input  logic [NREQ-1:0][BLK_AD_AW-1:0] ad_size_i,
  input  logic [NREQ-1:0][BLK_PT_AW-1:0] pt_size_i,
  input  logic [NREQ-1:0][7:0]           delay_i,
  input  logic [NREQ-1:0][63:0]          data_i,
  input  logic [NREQ-1:0]                data_valid_i,
  output logic [NREQ-1:0]                gnt_o,
  output logic [NREQ-1:0]                data_req_o,
  output logic [NREQ-1:0]                ct_valid_o,
  output logic [NREQ-1:0]                tag_valid_o,
  output logic [63:0]                    ct_o,
  output logic [127:0]                   tag_o,
  output logic [NREQ-1:0]                done_o,
  output logic                           core_start_o,
  output logic [127:0]                   core_key_o,
  output logic [127:0]                   core_nonce_o,
  output logic [BLK_AD_AW-1:0]           core_ad_size_o,
  output logic [BLK_PT_AW-1:0]           core_pt_size_o,
  output logic [7:0]                     core_delay_o,
  output logic [63:0]                    core_data_o,
  output logic                           core_data_valid_o,
  input  logic                           core_data_req_i,
  input  logic                           core_ready_i,
  input  logic                           core_done_i,
  input  logic                           core_ct_valid_i,
  input  logic                           core_tag_valid_i,
  input  logic [63:0]                    core_ct_i,
  input  logic [127:0]                   core_tag_i
`ifdef ASCON_SCHED_STATS_EN
  ,
  output logic [NREQ-1:0][15:0]          jobs_o
`endif
);

  localparam int IW = idx_width(NREQ);

  if (NREQ < 2 || NREQ > NREQ_MAX) begin : g_bad_nreq
    $error("ascon_sched: NREQ out of range");
  end

  sched_state_t    state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   owner;
  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_valid;
  logic [IW-1:0]   ptr_next;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_i),
    .ptr   (ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign ptr_next = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);

  // NOTE: all state here uses non-blocking assignment so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      ptr            <= '0;
      owner          <= '0;
      gnt_o          <= '0;
      core_start_o   <= 1'b0;
      core_key_o     <= '0;
      core_nonce_o   <= '0;
      core_ad_size_o <= '0;
      core_pt_size_o <= '0;
      core_delay_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (core_ready_i && arb_valid) begin
            state          <= START;
            owner          <= arb_idx;
            gnt_o          <= arb_gnt;
            core_start_o   <= 1'b1;
            core_key_o     <= key_i[arb_idx];
            core_nonce_o   <= nonce_i[arb_idx];
            core_ad_size_o <= ad_size_i[arb_idx];
            core_pt_size_o <= pt_size_i[arb_idx];
            core_delay_o   <= delay_i[arb_idx];
          end
        end
        START: begin
          state        <= BUSY;
          core_start_o <= 1'b0;
        end
        BUSY: begin
          // The finished owner moves to the back of the rotation.
          if (core_done_i) begin
            state <= IDLE;
            gnt_o <= '0;
            ptr   <= ptr_next;
          end
        end
        default: begin
          state        <= IDLE;
          gnt_o        <= '0;
          core_start_o <= 1'b0;
        end
      endcase
    end
  end

  // Core handshakes are steered to the owner only while the job is running.
  always_comb begin
    data_req_o        = '0;
    ct_valid_o        = '0;
    tag_valid_o       = '0;
    done_o            = '0;
    core_data_o       = '0;
    core_data_valid_o = 1'b0;
    if (state == BUSY) begin
      data_req_o[owner]  = core_data_req_i;
      ct_valid_o[owner]  = core_ct_valid_i;
      tag_valid_o[owner] = core_tag_valid_i;
      done_o[owner]      = core_done_i;
      core_data_o        = data_i[owner];
      core_data_valid_o  = data_valid_i[owner];
    end
  end

  assign ct_o  = core_ct_i;
  assign tag_o = core_tag_i;

`ifdef ASCON_SCHED_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      jobs_o <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (done_o[k] && jobs_o[k] != 16'hFFFF) jobs_o[k] <= jobs_o[k] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ascon_sched.sv
// Self-checking bench for ascon_sched: directed scenarios plus randomized jobs
// against a transaction-level round-robin model.
module tb_ascon_sched;

  localparam int NREQ = 2;
  localparam int AW   = 10;
  localparam int PW   = 10;

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic [NREQ-1:0]         req_i;
  logic [NREQ-1:0][127:0]  key_i;
  logic [NREQ-1:0][127:0]  nonce_i;
  logic [NREQ-1:0][AW-1:0] ad_size_i;
  logic [NREQ-1:0][PW-1:0] pt_size_i;
  logic [NREQ-1:0][7:0]    delay_i;
  logic [NREQ-1:0][63:0]   data_i;
  logic [NREQ-1:0]         data_valid_i;
  logic [NREQ-1:0]         gnt_o, data_req_o, ct_valid_o, tag_valid_o, done_o;
  logic [63:0]             ct_o;
  logic [127:0]            tag_o;
  logic                    core_start_o;
  logic [127:0]            core_key_o, core_nonce_o;
  logic [AW-1:0]           core_ad_size_o;
  logic [PW-1:0]           core_pt_size_o;
  logic [7:0]              core_delay_o;
  logic [63:0]             core_data_o;
  logic                    core_data_valid_o;
  logic                    core_data_req_i, core_ready_i, core_done_i;
  logic                    core_ct_valid_i, core_tag_valid_i;
  logic [63:0]             core_ct_i;
  logic [127:0]            core_tag_i;
`ifdef ASCON_SCHED_STATS_EN
  logic [NREQ-1:0][15:0]   jobs_o;
`endif

  ascon_sched #(.NREQ(NREQ), .BLK_AD_AW(AW), .BLK_PT_AW(PW)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .req_i             (req_i),
    .key_i             (key_i),
    .nonce_i           (nonce_i),
    .ad_size_i         (ad_size_i),
    .pt_size_i         (pt_size_i),
    .delay_i           (delay_i),
    .data_i            (data_i),
    .data_valid_i      (data_valid_i),
    .gnt_o             (gnt_o),
    .data_req_o        (data_req_o),
    .ct_valid_o        (ct_valid_o),
    .tag_valid_o       (tag_valid_o),
    .ct_o              (ct_o),
    .tag_o             (tag_o),
    .done_o            (done_o),
    .core_start_o      (core_start_o),
    .core_key_o        (core_key_o),
    .core_nonce_o      (core_nonce_o),
    .core_ad_size_o    (core_ad_size_o),
    .core_pt_size_o    (core_pt_size_o),
    .core_delay_o      (core_delay_o),
    .core_data_o       (core_data_o),
    .core_data_valid_o (core_data_valid_o),
    .core_data_req_i   (core_data_req_i),
    .core_ready_i      (core_ready_i),
    .core_done_i       (core_done_i),
    .core_ct_valid_i   (core_ct_valid_i),
    .core_tag_valid_i  (core_tag_valid_i),
    .core_ct_i         (core_ct_i),
    .core_tag_i        (core_tag_i)
`ifdef ASCON_SCHED_STATS_EN
    ,
    .jobs_o            (jobs_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int m_ptr    = 0;
  int m_jobs [NREQ];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reference arbitration: first requester at or after ptr, counting upward modulo NREQ.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  task automatic randomize_desc();
    for (int k = 0; k < NREQ; k++) begin
      key_i[k]     = {$urandom, $urandom, $urandom, $urandom};
      nonce_i[k]   = {$urandom, $urandom, $urandom, $urandom};
      ad_size_i[k] = AW'($urandom_range(0, (1 << AW) - 1));
      pt_size_i[k] = PW'($urandom_range(0, (1 << PW) - 1));
      delay_i[k]   = 8'($urandom_range(0, 255));
    end
  endtask

  // One full job from IDLE: grant, start, busy routing, done, release.
  task automatic do_job(input logic [NREQ-1:0] req, input int busy_len,
                        input bit drop_req, input bit fixed_sizes);
    int w;
    logic [NREQ-1:0] oh;
    logic dr, ctv, tgv;
    w = pick(req, m_ptr);
    oh = '0;
    oh[w] = 1'b1;
    randomize_desc();
    if (fixed_sizes) begin
      ad_size_i[1] = AW'(2);
      pt_size_i[1] = PW'(3);
    end
    req_i = req;
    core_ready_i = 1'b1;
    core_data_req_i = 1'b0;
    core_done_i = 1'b0;
    #1;
    check("idle_gnt", gnt_o, '0);
    check("idle_start", core_start_o, 1'b0);
    step();
    check("start_gnt", gnt_o, oh);
    check("start_pulse", core_start_o, 1'b1);
    check("desc_key", core_key_o, key_i[w]);
    check("desc_nonce", core_nonce_o, nonce_i[w]);
    check("desc_ad", core_ad_size_o, ad_size_i[w]);
    check("desc_pt", core_pt_size_o, pt_size_i[w]);
    check("desc_delay", core_delay_o, delay_i[w]);
    if (drop_req) req_i[w] = 1'b0;
    // Core status outside BUSY must be ignored.
    core_data_req_i = 1'b1;
    core_done_i = 1'b1;
    data_valid_i = '1;
    #1;
    check("start_data_req", data_req_o, '0);
    check("start_done", done_o, '0);
    check("start_dvalid", core_data_valid_o, 1'b0);
    step();
    core_done_i = 1'b0;
    core_data_req_i = 1'b0;
    check("busy_start", core_start_o, 1'b0);
    check("busy_gnt", gnt_o, oh);
    for (int c = 0; c < busy_len; c++) begin
      dr  = 1'($urandom_range(0, 1));
      ctv = 1'($urandom_range(0, 1));
      tgv = 1'($urandom_range(0, 1));
      core_data_req_i  = dr;
      core_ct_valid_i  = ctv;
      core_tag_valid_i = tgv;
      core_ct_i  = {$urandom, $urandom};
      core_tag_i = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < NREQ; k++) data_i[k] = {$urandom, $urandom};
      data_valid_i = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      #1;
      check("busy_data_req", data_req_o, dr ? oh : '0);
      check("busy_ct_valid", ct_valid_o, ctv ? oh : '0);
      check("busy_tag_valid", tag_valid_o, tgv ? oh : '0);
      check("busy_data", core_data_o, data_i[w]);
      check("busy_dvalid", core_data_valid_o, data_valid_i[w]);
      check("busy_ct", ct_o, core_ct_i);
      check("busy_tag", tag_o, core_tag_i);
      check("busy_no_done", done_o, '0);
      step();
    end
    core_data_req_i = 1'b0;
    core_ct_valid_i = 1'b0;
    core_tag_valid_i = 1'b0;
    core_done_i = 1'b1;
    #1;
    check("done_pulse", done_o, oh);
    step();
    core_done_i = 1'b0;
    #1;
    check("release_gnt", gnt_o, '0);
    check("release_start", core_start_o, 1'b0);
    check("release_done", done_o, '0);
    m_ptr = (w + 1) % NREQ;
    m_jobs[w]++;
  endtask

  initial begin
    logic [NREQ-1:0] rq;
    rst_i = 1'b1;
    req_i = '0;
    data_i = '0;
    data_valid_i = '0;
    core_data_req_i = 1'b0;
    core_ready_i = 1'b0;
    core_done_i = 1'b0;
    core_ct_valid_i = 1'b0;
    core_tag_valid_i = 1'b0;
    core_ct_i = '0;
    core_tag_i = '0;
    randomize_desc();
    for (int k = 0; k < NREQ; k++) m_jobs[k] = 0;
    step();
    step();
    rst_i = 1'b0;
    #1;
    check("rst_gnt", gnt_o, '0);
    check("rst_start", core_start_o, 1'b0);
    check("rst_key", core_key_o, '0);
    check("rst_nonce", core_nonce_o, '0);
    check("rst_sizes", {core_ad_size_o, core_pt_size_o, core_delay_o}, '0);
    check("rst_dvalid", core_data_valid_o, 1'b0);
    check("rst_done", done_o, '0);

    // Single job on requester 1 with fixed sizes.
    do_job(2'b10, 5, 1'b0, 1'b1);
    // Simultaneous requests: 0 first, then 1 two cycles after done.
    do_job(2'b11, 3, 1'b0, 1'b0);
    do_job(2'b11, 3, 1'b0, 1'b0);
    // Requester 0 holding while 1 pending must alternate.
    for (int j = 0; j < 4; j++) do_job(2'b11, 2, 1'b0, 1'b0);

    // Core not ready: no grant, no pointer movement.
    req_i = 2'b11;
    core_ready_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check("notready_gnt", gnt_o, '0);
      check("notready_start", core_start_o, 1'b0);
    end
    do_job(2'b11, 2, 1'b0, 1'b0);

    // Leave ptr at 1, then reset in the middle of a job on requester 1.
    do_job(2'b01, 1, 1'b0, 1'b0);
    req_i = 2'b10;
    step();
    step();
    core_data_req_i = 1'b1;
    #1;
    check("abort_busy_req", data_req_o, 2'b10);
    rst_i = 1'b1;
    req_i = '0;
    step();
    rst_i = 1'b0;
    core_data_req_i = 1'b0;
    #1;
    check("abort_gnt", gnt_o, '0);
    check("abort_start", core_start_o, 1'b0);
    check("abort_key", core_key_o, '0);
    check("abort_data_req", data_req_o, '0);
    check("abort_done", done_o, '0);
    m_ptr = 0;
    for (int k = 0; k < NREQ; k++) m_jobs[k] = 0;
    do_job(2'b11, 2, 1'b0, 1'b0);
    do_job(2'b01, 1, 1'b1, 1'b0);
    do_job(2'b01, 1, 1'b0, 1'b0);
`ifdef ASCON_SCHED_STATS_EN
    check("jobs_req0", jobs_o[0], 16'd3);
    check("jobs_req1", jobs_o[1], 16'd0);
`endif

    // Randomized traffic.
    for (int j = 0; j < 20; j++) begin
      rq = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      do_job(rq, $urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'b0);
    end
`ifdef ASCON_SCHED_STATS_EN
    for (int k = 0; k < NREQ; k++) check("jobs_final", jobs_o[k], 16'(m_jobs[k]));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
